// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Provides the FSM state encoding, the data bit count, the parity modes and
// a parity helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    // Parity bit that makes the frame's total count of ones even (or odd).
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 mode);
        return (^data) ^ mode;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   ena        : global enable; low freezes the count
//   clear      : forces the count back to zero
//   tick       : high on the last cycle of each bit period
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counts 0..CLKS_PER_BIT-1 and wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ena) begin
            if (clear || (r_cnt == LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_byte.sv
// UART transmitter: accepts one byte per valid/ready handshake and sends it
// LSB first as start, 8 data, optional parity and 1 or 2 stop bits.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   ena        : global enable; low freezes all state and drops ready
//   data_in    : byte to send, sampled on acceptance
//   valid      : producer has a byte
//   ready      : idle and enabled (combinational)
//   tx         : serial line, idle high, registered
//   busy       : frame in progress
//   done       : one-cycle pulse when a frame completes
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam logic       PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_idx;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    logic w_tick;
    logic w_accept;
    logic w_clear;

    assign ready    = (r_state == ST_IDLE) && ena;
    assign w_accept = valid && ready;
    // Holding the timer at zero while idle makes the first bit a full period.
    assign w_clear  = (r_state == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Frame sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= data_in;
                        r_parity  <= calc_parity(data_in, PAR_MODE);
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_DATA) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx      <= 1'b1;
                        r_bit_idx <= '0;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // r_bit_idx counts stop bits here.
                    if (w_tick) begin
                        if (r_bit_idx == LAST_STOP) begin
                            r_bit_idx <= '0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte: four instances (8N1, even parity,
// odd parity, even parity with two stop bits), all at 4 clocks per bit.
module tb_uart_tx_byte;

    localparam int CPB = 4;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       pbit;
        int         flen;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] data_in;
    logic       valid   [4];
    logic       w_ready [4];
    logic       w_tx    [4];
    logic       w_busy  [4];
    logic       w_done  [4];

    int cfg_pe [4] = '{0, 1, 1, 1};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid(valid[0]),
        .ready(w_ready[0]), .tx(w_tx[0]), .busy(w_busy[0]), .done(w_done[0]));
    uart_tx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid(valid[1]),
        .ready(w_ready[1]), .tx(w_tx[1]), .busy(w_busy[1]), .done(w_done[1]));
    uart_tx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid(valid[2]),
        .ready(w_ready[2]), .tx(w_tx[2]), .busy(w_busy[2]), .done(w_done[2]));
    uart_tx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_2stop (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid(valid[3]),
        .ready(w_ready[3]), .tx(w_tx[3]), .busy(w_busy[3]), .done(w_done[3]));

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %02h want %02h", name, $time, act, exp);
        end
    endtask

    // Expected line level during serial bit b of a frame.
    function automatic logic exp_bit(input int idx, input logic [7:0] d,
                                     input logic pbit, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && cfg_pe[idx] != 0) return pbit;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until the next edge will accept for instance idx.
    task automatic wait_ready(input int idx, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (w_ready[idx]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_ready inst %0d: got ready=0 want ready=1 within 200 cycles", idx);
        end
    endtask

    // Sends one byte and checks every cycle of the frame plus the done pulse.
    task automatic run_frame(input int idx, input logic [7:0] d, input logic pbit, input int flen);
        bit ok;
        data_in    = d;
        valid[idx] = 1'b1;
        wait_ready(idx, ok);
        if (!ok) begin
            valid[idx] = 1'b0;
            return;
        end
        step();
        valid[idx] = 1'b0;
        data_in    = ~d;
        check1("accept_busy", w_busy[idx], 1'b1);
        for (int j = 0; j < flen; j++) begin
            if (j > 0) step();
            check1("frame_tx", w_tx[idx], exp_bit(idx, d, pbit, j / CPB));
            check1("frame_ready_low", w_ready[idx], 1'b0);
            check1("frame_done_low", w_done[idx], 1'b0);
        end
        step();
        check1("end_done", w_done[idx], 1'b1);
        check1("end_tx", w_tx[idx], 1'b1);
        check1("end_busy", w_busy[idx], 1'b0);
        check1("end_ready", w_ready[idx], 1'b1);
        step();
        check1("done_one_cycle", w_done[idx], 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        bit   ok;
        int   ndone;
        int   e;
        int   j;
        logic [7:0] cnt8;
        logic [7:0] acc_byte;
        logic [7:0] rx;
        logic [7:0] prev_rx;
        bit   have_prev;
        bit   will_acc;

        vecs[0] = '{0, 8'hA5, 1'b0, 40};
        vecs[1] = '{1, 8'h07, 1'b1, 44};
        vecs[2] = '{2, 8'h07, 1'b0, 44};
        vecs[3] = '{3, 8'h07, 1'b1, 48};
        vecs[4] = '{0, 8'h00, 1'b0, 40};
        vecs[5] = '{0, 8'hFF, 1'b0, 40};
        vecs[6] = '{1, 8'hA5, 1'b0, 44};
        vecs[7] = '{2, 8'h3C, 1'b1, 44};

        rst_n   = 1'b0;
        ena     = 1'b1;
        data_in = 8'h00;
        for (int i = 0; i < 4; i++) valid[i] = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check1("reset_tx", w_tx[i], 1'b1);
            check1("reset_busy", w_busy[i], 1'b0);
            check1("reset_done", w_done[i], 1'b0);
        end
        rst_n = 1'b1;
        step();

        // Table-driven frames across all configurations.
        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].idx, vecs[v].data, vecs[v].pbit, vecs[v].flen);
        end

        // Back-to-back 0x00 then 0xFF with valid held high.
        data_in  = 8'h00;
        valid[0] = 1'b1;
        wait_ready(0, ok);
        ndone = 0;
        if (ok) begin
            for (int c = 0; c < 83; c++) begin
                step();
                if (c == 0) data_in = 8'hFF;
                if (w_done[0]) ndone++;
                if (c < 82) begin
                    if (c % 41 == 40) begin
                        check1("b2b_idle_tx", w_tx[0], 1'b1);
                    end else begin
                        check1("b2b_tx", w_tx[0],
                               exp_bit(0, (c < 41) ? 8'h00 : 8'hFF, 1'b0, (c % 41) / CPB));
                    end
                end
                if (c == 81) valid[0] = 1'b0;
            end
            check1("b2b_no_third", w_ready[0], 1'b1);
            total++;
            if (ndone != 2) begin
                bad++;
                $display("FAIL b2b_done_count: got %0d want 2", ndone);
            end
        end
        valid[0] = 1'b0;
        step();

        // Reset during data bit D3 abandons the frame.
        data_in  = 8'hA5;
        valid[0] = 1'b1;
        wait_ready(0, ok);
        step();
        valid[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check1("pre_reset_d3", w_tx[0], 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check1("midrst_tx", w_tx[0], 1'b1);
        check1("midrst_busy", w_busy[0], 1'b0);
        check1("midrst_ready", w_ready[0], 1'b1);
        check1("midrst_done", w_done[0], 1'b0);
        ndone = 0;
        for (int c = 0; c < 45; c++) begin
            step();
            if (w_done[0] || !w_tx[0]) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL midrst_quiet: got %0d active cycles want 0", ndone);
        end
        run_frame(0, 8'h3C, 1'b0, 40);

        // ena low for 5 cycles during START stretches the frame by 5.
        data_in  = 8'hA5;
        valid[0] = 1'b1;
        wait_ready(0, ok);
        step();
        valid[0] = 1'b0;
        for (int c = 0; c <= 46; c++) begin
            if (c > 0) step();
            e = c - ((c - 1 < 0) ? 0 : ((c - 1 > 5) ? 5 : c - 1));
            if (c >= 2 && c <= 6) check1("ena_ready_low", w_ready[0], 1'b0);
            if (e < 40) begin
                check1("ena_tx", w_tx[0], exp_bit(0, 8'hA5, 1'b0, e / CPB));
                check1("ena_done_low", w_done[0], 1'b0);
            end else if (c == 45) begin
                check1("ena_done", w_done[0], 1'b1);
                check1("ena_end_tx", w_tx[0], 1'b1);
            end else begin
                check1("ena_done_after", w_done[0], 1'b0);
            end
            if (c == 1) ena = 1'b0;
            if (c == 6) ena = 1'b1;
        end

        // Free-running counter feeding data_in with valid held high.
        cnt8      = 8'h10;
        j         = 1000;
        rx        = 8'h00;
        acc_byte  = 8'h00;
        prev_rx   = 8'h00;
        have_prev = 1'b0;
        valid[0]  = 1'b1;
        for (int c = 0; c < 130; c++) begin
            data_in  = cnt8;
            will_acc = w_ready[0];
            step();
            if (will_acc) begin
                acc_byte = cnt8;
                j        = 0;
                rx       = 8'h00;
            end else begin
                j++;
            end
            if (j >= 6 && j <= 34 && (j - 2) % CPB == 0) rx[(j - 2) / CPB - 1] = w_tx[0];
            if (j == 34) begin
                check8("integ_byte", rx, acc_byte);
                if (have_prev) check8("integ_step", rx, prev_rx + 8'd41);
                prev_rx   = rx;
                have_prev = 1'b1;
            end
            cnt8 = cnt8 + 8'd1;
        end
        valid[0] = 1'b0;
        wait_ready(0, ok);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
